// File: rtl/mp_limb_adder.sv
// mp_limb_adder: multi-cycle multi-precision adder controller.
// Two W-bit operands are added one N-bit limb per cycle through a single
// n_adder, LSB limb first, with the inter-limb carry held in a register.
// Optional macro OVF_FLAG_EN adds the out_ovf signed-overflow output.

// n_adder: plain N-bit ripple adder with carry-in and carry-out.
module n_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         ci,
  output logic [N-1:0] S,
  output logic         co
);

  assign {co, S} = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, ci};

endmodule

module mp_limb_adder #(
  parameter int N     = 4,
  parameter int LIMBS = 4,
  parameter int W     = N * LIMBS
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_ci,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_co
`ifdef OVF_FLAG_EN
  ,
  output logic         out_ovf
`endif
);

  localparam int IDX_W = (LIMBS > 1) ? $clog2(LIMBS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LIMBS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     work_q, work_d;      // partial sum built limb by limb
  logic [W-1:0]     out_sum_q, out_sum_d;
  logic             out_co_q, out_co_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
`ifdef OVF_FLAG_EN
  logic             out_ovf_q, out_ovf_d;
`endif

  // Limb datapath: the selected limb pair goes through the shared adder.
  logic [N-1:0] add_a, add_b, add_s;
  logic         add_co;
  logic [W-1:0] sum_asm;

  assign add_a = a_q[idx_q*N +: N];
  assign add_b = b_q[idx_q*N +: N];

  n_adder #(.N(N)) u_n_adder (
    .A  (add_a),
    .B  (add_b),
    .ci (carry_q),
    .S  (add_s),
    .co (add_co)
  );

  // Partial sum with the current limb merged in; on the last limb this is the full result.
  always_comb begin
    sum_asm = work_q;
    sum_asm[idx_q*N +: N] = add_s;
  end

  // Next-state and datapath update for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    work_d    = work_q;
    out_sum_d = out_sum_q;
    out_co_d  = out_co_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
`ifdef OVF_FLAG_EN
    out_ovf_d = out_ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_ci;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d  = sum_asm;
        carry_d = add_co;
        if (idx_q == IDX_LAST) begin
          // Final limb: publish the result; idx is left in place rather than wrapped.
          out_sum_d = sum_asm;
          out_co_d  = add_co;
`ifdef OVF_FLAG_EN
          out_ovf_d = (a_q[W-1] == b_q[W-1]) && (add_s[N-1] != a_q[W-1]);
`endif
          state_d   = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        // Result held until taken; IDLE next so one bubble cycle follows.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      work_q    <= '0;
      out_sum_q <= '0;
      out_co_q  <= 1'b0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
`ifdef OVF_FLAG_EN
      out_ovf_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      work_q    <= work_d;
      out_sum_q <= out_sum_d;
      out_co_q  <= out_co_d;
      carry_q   <= carry_d;
      idx_q     <= idx_d;
`ifdef OVF_FLAG_EN
      out_ovf_q <= out_ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = out_sum_q;
  assign out_co    = out_co_q;
`ifdef OVF_FLAG_EN
  assign out_ovf   = out_ovf_q;
`endif

endmodule
